// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select codes and the packed bundle of stage-register controls.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_we;
        logic mem_wb_we;
        logic mem_wb_bubble;
    } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic                  dmem_req;
    logic                  dmem_ready;

    logic                  pc_we;
    logic                  if_id_we;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_we;
    logic                  mem_wb_we;
    logic                  mem_wb_bubble;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_rd, mem_reg_write, wb_rd,
               wb_reg_write, dmem_req, dmem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
               mem_wb_bubble, fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_rd, mem_reg_write, wb_rd,
               wb_reg_write, dmem_req, dmem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
               mem_wb_bubble, fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/forward_unit.sv
// EX-operand bypass select for one source register; the younger MEM result wins
// over WB, and x0 is never bypassed because it is hard-wired to zero.
module forward_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_reg_write_i,
    output logic [1:0]            fwd_sel_o
);
    always_comb begin
        fwd_sel_o = FWD_REG;
        if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stage-register enables
// and flushes, EX forwarding, dmem wait freeze with timeout trap, stall counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int WAIT_MAX   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int WAIT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
    ctrl_t               ctrl;
    logic                freeze, load_use, branch_flush;

    logic [REG_ADDR_W-1:0] ex_rs   [2];
    logic [1:0]            fwd_sel [2];

    assign ex_rs[0] = bus.ex_rs1;
    assign ex_rs[1] = bus.ex_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
                .ex_rs_i         (ex_rs[gi]),
                .mem_rd_i        (bus.mem_rd),
                .mem_reg_write_i (bus.mem_reg_write),
                .wb_rd_i         (bus.wb_rd),
                .wb_reg_write_i  (bus.wb_reg_write),
                .fwd_sel_o       (fwd_sel[gi])
            );
        end
    endgenerate

    assign freeze   = bus.dmem_req & ~bus.dmem_ready;
    assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                      ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                       (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!freeze) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_TRAP: ;
            default: state_d = ST_RUN;
        endcase
    end

    // Priority: reset force > TRAP > freeze > branch > load-use > normal.
    always_comb begin
        ctrl         = '0;
        branch_flush = 1'b0;
        if (reset) begin
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_flush   = 1'b1;
            ctrl.mem_wb_bubble = 1'b1;
        end else if (state_q == ST_TRAP) begin
            ctrl = '0;
        end else if (freeze) begin
            ctrl.mem_wb_we     = 1'b1;
            ctrl.mem_wb_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ctrl.pc_we       = 1'b1;
            ctrl.if_id_we    = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            ctrl.ex_mem_we   = 1'b1;
            ctrl.mem_wb_we   = 1'b1;
            branch_flush     = 1'b1;
        end else if (load_use) begin
            ctrl.id_ex_flush = 1'b1;
            ctrl.ex_mem_we   = 1'b1;
            ctrl.mem_wb_we   = 1'b1;
        end else begin
            ctrl.pc_we     = 1'b1;
            ctrl.if_id_we  = 1'b1;
            ctrl.ex_mem_we = 1'b1;
            ctrl.mem_wb_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!ctrl.pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we         = ctrl.pc_we;
    assign bus.if_id_we      = ctrl.if_id_we;
    assign bus.if_id_flush   = ctrl.if_id_flush;
    assign bus.id_ex_flush   = ctrl.id_ex_flush;
    assign bus.ex_mem_we     = ctrl.ex_mem_we;
    assign bus.mem_wb_we     = ctrl.mem_wb_we;
    assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
    assign bus.fwd_a         = reset ? FWD_REG : fwd_sel[0];
    assign bus.fwd_b         = reset ? FWD_REG : fwd_sel[1];
    assign bus.mem_timeout   = (state_q == ST_TRAP);
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed
// by random traffic, checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int RW = 5;
    localparam int CW = 6;
    localparam int WM = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          reset;
        logic [RW-1:0] id_rs1, id_rs2;
        logic          use1, use2;
        logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
        logic          ex_mem_read, br;
        logic [RW-1:0] mem_rd;
        logic          mem_rw;
        logic [RW-1:0] wb_rd;
        logic          wb_rw;
        logic          req, rdy;
    } stim_t;

    // ctrl bit order: pc_we if_id_we if_id_flush id_ex_flush ex_mem_we mem_wb_we mem_wb_bubble
    typedef struct {
        int         id;
        logic [6:0] ctrl;
        logic [6:0] mask;
        logic [1:0] fa, fb;
        logic       to;
        int         sc, fc;
    } exp_t;

    logic clk;
    logic reset;
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .WAIT_MAX(WM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   txn_id   = 0;

    bit m_trap    = 0;
    int m_consec  = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs, input logic [RW-1:0] mrd,
                                           input logic mw, input logic [RW-1:0] wrd, input logic ww);
        if (mw && mrd != 0 && mrd == rs) return 2'b10;
        if (ww && wrd != 0 && wrd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s txn %0d: got %0h expected %0h", name, id, act, expv);
        end
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        reset               = s.reset;
        bus.id_rs1          = s.id_rs1;
        bus.id_rs2          = s.id_rs2;
        bus.id_use_rs1      = s.use1;
        bus.id_use_rs2      = s.use2;
        bus.ex_rs1          = s.ex_rs1;
        bus.ex_rs2          = s.ex_rs2;
        bus.ex_rd           = s.ex_rd;
        bus.ex_mem_read     = s.ex_mem_read;
        bus.ex_branch_taken = s.br;
        bus.mem_rd          = s.mem_rd;
        bus.mem_reg_write   = s.mem_rw;
        bus.wb_rd           = s.wb_rd;
        bus.wb_reg_write    = s.wb_rw;
        bus.dmem_req        = s.req;
        bus.dmem_ready      = s.rdy;

        e.id   = txn_id++;
        e.sc   = m_stalls;
        e.fc   = m_flushes;
        e.to   = m_trap;
        e.mask = 7'h7F;
        e.fa   = fwd_ref(s.ex_rs1, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
        e.fb   = fwd_ref(s.ex_rs2, s.mem_rd, s.mem_rw, s.wb_rd, s.wb_rw);
        lu = s.ex_mem_read && s.ex_rd != 0 &&
             ((s.use1 && s.ex_rd == s.id_rs1) || (s.use2 && s.ex_rd == s.id_rs2));

        if (s.reset) begin
            e.ctrl = 7'b0011001;
            e.fa = 2'b00;
            e.fb = 2'b00;
            m_trap = 0; m_consec = 0; m_stalls = 0; m_flushes = 0;
        end else if (m_trap) begin
            e.ctrl = 7'b0000000;
            e.mask = 7'b1100110;
            if (m_stalls < CMAX) m_stalls++;
        end else if (s.req && !s.rdy) begin
            e.ctrl = 7'b0000011;
            m_consec++;
            if (m_consec == WM) m_trap = 1;
            if (m_stalls < CMAX) m_stalls++;
        end else begin
            m_consec = 0;
            if (s.br) begin
                e.ctrl = 7'b1111110;
                if (m_flushes < CMAX) m_flushes++;
            end else if (lu) begin
                e.ctrl = 7'b0001110;
                if (m_stalls < CMAX) m_stalls++;
            end else begin
                e.ctrl = 7'b1100110;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so one expected entry per cycle.
    initial begin
        exp_t  e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush,
                       bus.ex_mem_we, bus.mem_wb_we, bus.mem_wb_bubble};
                $display("txn %0d rst=%0b ctrl=%b fwd=%b/%b to=%0b stall=%0d flush=%0d",
                         e.id, reset, act, bus.fwd_a, bus.fwd_b, bus.mem_timeout,
                         bus.stall_cnt, bus.flush_cnt);
                chk("ctrl", e.id, 32'(act & e.mask), 32'(e.ctrl & e.mask));
                chk("fwd_a", e.id, 32'(bus.fwd_a), 32'(e.fa));
                chk("fwd_b", e.id, 32'(bus.fwd_b), 32'(e.fb));
                chk("mem_timeout", e.id, 32'(bus.mem_timeout), 32'(e.to));
                chk("stall_cnt", e.id, 32'(bus.stall_cnt), 32'(e.sc));
                chk("flush_cnt", e.id, 32'(bus.flush_cnt), 32'(e.fc));
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_rd = '0; bus.mem_reg_write = 1'b0;
        bus.wb_rd = '0; bus.wb_reg_write = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;

        s = '0; s.reset = 1'b1;
        apply(s); apply(s);

        // load x5 in EX, ID instruction reads x5
        s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 5'd5; s.id_rs1 = 5'd5; s.use1 = 1'b1;
        apply(s);
        s = '0; apply(s);

        // MEM and WB both write x3; then MEM targets x0
        s = '0; s.mem_rw = 1'b1; s.mem_rd = 5'd3; s.wb_rw = 1'b1; s.wb_rd = 5'd3;
        s.ex_rs1 = 5'd3; s.ex_rs2 = 5'd3;
        apply(s);
        s.mem_rd = 5'd0; apply(s);

        // branch together with a load-use
        s = '0; s.br = 1'b1; s.ex_mem_read = 1'b1; s.ex_rd = 5'd7; s.id_rs2 = 5'd7; s.use2 = 1'b1;
        apply(s);
        s = '0; apply(s);

        // three wait states, then ready (branch held during freeze)
        s = '0; s.req = 1'b1; s.br = 1'b1;
        repeat (3) apply(s);
        s.rdy = 1'b1; apply(s);
        s = '0; apply(s);

        // wait states up to the timeout, trap, then reset
        s = '0; s.req = 1'b1;
        repeat (WM) apply(s);
        s = '0; repeat (3) apply(s);
        s.reset = 1'b1; apply(s);
        s = '0; apply(s);

        // reset in the middle of a wait
        s = '0; s.req = 1'b1;
        repeat (2) apply(s);
        s.reset = 1'b1; apply(s);
        s = '0; repeat (2) apply(s);

        for (int i = 0; i < 2000; i++) begin
            s.reset       = ($urandom_range(0, 199) == 0);
            s.id_rs1      = RW'($urandom_range(0, 3));
            s.id_rs2      = RW'($urandom_range(0, 3));
            s.use1        = 1'($urandom_range(0, 1));
            s.use2        = 1'($urandom_range(0, 1));
            s.ex_rs1      = RW'($urandom_range(0, 3));
            s.ex_rs2      = RW'($urandom_range(0, 3));
            s.ex_rd       = RW'($urandom_range(0, 3));
            s.ex_mem_read = 1'($urandom_range(0, 1));
            s.br          = ($urandom_range(0, 4) == 0);
            s.mem_rd      = RW'($urandom_range(0, 3));
            s.mem_rw      = 1'($urandom_range(0, 1));
            s.wb_rd       = RW'($urandom_range(0, 3));
            s.wb_rw       = 1'($urandom_range(0, 1));
            s.req         = ($urandom_range(0, 2) != 0);
            s.rdy         = ($urandom_range(0, 9) < (((i / 250) % 2 == 1) ? 2 : 7));
            apply(s);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", txn_id, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
